// File: rtl/fbuf_scanout.sv
// Framebuffer scanout: raster timing counters, BRAM read addressing and a
// two-stage pipeline producing RGB888 video with syncs and data enable.
module fbuf_scanout #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  output logic                       fbuf_rd_en,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_rd_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rd_data,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [23:0]                vid_rgb,
  output logic                       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                     state_q, state_d;
  logic [HW-1:0]              h_cnt_q, h_cnt_d;
  logic [VW-1:0]              v_cnt_q, v_cnt_d;
  logic [FBUF_ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;

  logic s1_active_q, s1_active_d;
  logic s1_hs_q, s1_hs_d;
  logic s1_vs_q, s1_vs_d;
  logic s1_first_q, s1_first_d;

  logic        vid_hsync_q, vid_hsync_d;
  logic        vid_vsync_q, vid_vsync_d;
  logic        vid_de_q, vid_de_d;
  logic [23:0] vid_rgb_q, vid_rgb_d;
  logic        frame_start_q, frame_start_d;

  logic [7:0] px;

  // Counter stage, raster decode and RGB332 -> RGB888 expansion.
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pix_cnt_d = pix_cnt_q;

    s1_active_d = (state_q == S_RUN) && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    s1_hs_d     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    s1_vs_d     = (state_q == S_RUN) && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    s1_first_d  = s1_active_d && (h_cnt_q == '0) && (v_cnt_q == '0);

    unique case (state_q)
      S_IDLE: begin
        h_cnt_d   = '0;
        v_cnt_d   = '0;
        pix_cnt_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (s1_active_d) pix_cnt_d = pix_cnt_q + FBUF_ADDR_WIDTH'(1);
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            // Frame boundary: the only point where scanout may stop.
            v_cnt_d   = '0;
            pix_cnt_d = '0;
            if (!enable) state_d = S_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    px            = 8'(fbuf_rd_data);
    vid_de_d      = s1_active_q;
    vid_hsync_d   = !s1_hs_q;
    vid_vsync_d   = !s1_vs_q;
    frame_start_d = s1_first_q;
    vid_rgb_d     = s1_active_q ? {px[7:5], px[7:5], px[7:6],
                                   px[4:2], px[4:2], px[4:3],
                                   px[1:0], px[1:0], px[1:0], px[1:0]} : 24'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_cnt_q     <= '0;
      s1_active_q   <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_first_q    <= 1'b0;
      vid_hsync_q   <= 1'b1;
      vid_vsync_q   <= 1'b1;
      vid_de_q      <= 1'b0;
      vid_rgb_q     <= 24'h0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      s1_active_q   <= s1_active_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_first_q    <= s1_first_d;
      vid_hsync_q   <= vid_hsync_d;
      vid_vsync_q   <= vid_vsync_d;
      vid_de_q      <= vid_de_d;
      vid_rgb_q     <= vid_rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fbuf_rd_en   = s1_active_d;
  assign fbuf_rd_addr = pix_cnt_q;
  assign vid_hsync    = vid_hsync_q;
  assign vid_vsync    = vid_vsync_q;
  assign vid_de       = vid_de_q;
  assign vid_rgb      = vid_rgb_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_fbuf_scanout.sv
// Scoreboard bench for fbuf_scanout: small-frame instance checked against a
// frame-position reference model, plus a default-timing instance.
module tb_fbuf_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, en_dflt;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [7:0]  rd_data;
  logic        hs, vs, de, fs;
  logic [23:0] rgb;

  logic        d_rd_en;
  logic [18:0] d_rd_addr;
  logic [7:0]  d_rd_data;
  logic        d_hs, d_vs, d_de, d_fs;
  logic [23:0] d_rgb;
  assign d_rd_data = 8'h00;

  fbuf_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fbuf_rd_en(rd_en), .fbuf_rd_addr(rd_addr), .fbuf_rd_data(rd_data),
    .vid_hsync(hs), .vid_vsync(vs), .vid_de(de), .vid_rgb(rgb),
    .frame_start(fs)
  );

  fbuf_scanout u_dflt (
    .clk(clk), .rst(rst), .enable(en_dflt),
    .fbuf_rd_en(d_rd_en), .fbuf_rd_addr(d_rd_addr), .fbuf_rd_data(d_rd_data),
    .vid_hsync(d_hs), .vid_vsync(d_vs), .vid_de(d_de), .vid_rgb(d_rgb),
    .frame_start(d_fs)
  );

  // BRAM model: one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[7:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event-missing expected event-present", nm);
  endtask

  typedef struct packed {logic de; logic hs; logic vs;} sync_t;

  logic [23:0] pix_q [$];
  logic [18:0] addr_q [$];
  sync_t       sync_q [$];

  logic [23:0] exp_tab [4];
  initial exp_tab = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h9292AA};

  // Reference colour expansion: scale each channel by arithmetic replication.
  function automatic logic [23:0] ref_rgb(input logic [7:0] d);
    int r, g, b, r8, g8, b8;
    r  = (d >> 5) & 7;
    g  = (d >> 2) & 7;
    b  = d & 3;
    r8 = (r << 5) | (r << 2) | (r >> 1);
    g8 = (g << 5) | (g << 2) | (g >> 1);
    b8 = b * 85;
    return {8'(r8), 8'(g8), 8'(b8)};
  endfunction

  // Expected output of one 7x6 frame (4x3 visible), starting at frame_start.
  task automatic push_frame();
    sync_t s;
    for (int i = 0; i < 12; i++) begin
      addr_q.push_back(19'(i));
      if (i < 4) pix_q.push_back(exp_tab[i]);
      else       pix_q.push_back(ref_rgb(mem[i]));
    end
    for (int p = 0; p < 42; p++) begin
      int line, col;
      line = p / 7;
      col  = p % 7;
      s.de = (line < 3) && (col < 4);
      s.hs = (col != 5);
      s.vs = (line != 4);
      sync_q.push_back(s);
    end
  endtask

  // Monitor: pops expectations as the DUT presents output.
  bit       mon_en = 1'b0;
  int       win = -1;
  bit [1:0] hist = 2'b00;

  always @(negedge clk) begin
    if (!mon_en) begin
      win  = -1;
      hist = 2'b00;
    end else begin
      chk("de_latency", 32'(de), 32'(hist[1]));
      hist = {hist[0], rd_en};
      if (rd_en) begin
        if (addr_q.size() == 0) fail("addr_unexpected");
        else chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
      if (de) begin
        if (pix_q.size() == 0) fail("pixel_unexpected");
        else chk("rgb", 32'(rgb), 32'(pix_q.pop_front()));
      end else begin
        chk("rgb_blank", 32'(rgb), 32'h0);
      end
      if (win < 0 && fs) win = 0;
      if (win >= 0) begin
        if (sync_q.size() == 0) fail("sync_unexpected");
        else begin
          sync_t s;
          s = sync_q.pop_front();
          chk("de", 32'(de), 32'(s.de));
          chk("hsync", 32'(hs), 32'(s.hs));
          chk("vsync", 32'(vs), 32'(s.vs));
          chk("frame_start", 32'(fs), 32'(win == 0));
        end
        win++;
        if (win == 42) win = -1;
      end else begin
        chk("idle_out", {28'h0, hs, vs, de, fs}, 32'b1100);
      end
    end
  end

  task automatic check_drained(input string tag);
    chk({tag, "_pix_left"}, 32'(pix_q.size()), 32'd0);
    chk({tag, "_addr_left"}, 32'(addr_q.size()), 32'd0);
    chk({tag, "_sync_left"}, 32'(sync_q.size()), 32'd0);
  endtask

  // Run n frames, dropping enable on line 1 of the last one.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) push_frame();
    @(posedge clk); #1 enable = 1'b1;
    repeat (42 * (n - 1) + 10) @(posedge clk);
    #1 enable = 1'b0;
    repeat (62) @(posedge clk);
    check_drained("run");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_hsync"}, 32'(hs), 32'd1);
    chk({tag, "_vsync"}, 32'(vs), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_frame_start"}, 32'(fs), 32'd0);
  endtask

  // Default 640x480 timing: hsync/de pattern over the first three lines.
  bit dflt_done = 1'b0;
  initial begin
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (d_fs !== 1'b1 && t < 200);
    if (d_fs !== 1'b1) fail("dflt_frame_start_timeout");
    else begin
      for (int c = 0; c < 2400; c++) begin
        int col;
        logic ede, ehs;
        col = c % 800;
        ede = (col < 640);
        ehs = !(col >= 656 && col < 752);
        chk("dflt_timing", {27'h0, d_de, d_hs, d_vs, d_fs, (d_rgb != 24'h0)},
            {27'h0, ede, ehs, 1'b1, (c == 0), 1'b0});
        @(negedge clk);
      end
    end
    dflt_done = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'h92;

    rst = 1'b1; enable = 1'b1; en_dflt = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0; enable = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    run_frames(2);
    run_frames(1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 4; i < 256; i++) mem[i] = 8'($urandom);
      run_frames(int'($urandom_range(1, 3)));
    end

    t = 0;
    while (!dflt_done && t < 5000) begin @(posedge clk); t++; end
    if (!dflt_done) fail("dflt_done_timeout");

    // Mid-frame reset: pulse rst while pixel 5 is being fetched.
    mon_en = 1'b0;
    pix_q.delete(); addr_q.delete(); sync_q.delete();
    @(posedge clk); #1 enable = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!(rd_en === 1'b1 && rd_addr === 19'd5) && t < 200);
    if (!(rd_en === 1'b1 && rd_addr === 19'd5)) fail("mid_addr5_timeout");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    push_frame();
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    repeat (62) @(posedge clk);
    check_drained("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
